rr_prio_encoder: RTL



---
 rtl/rr_prio_encoder_pkg.sv | 19 +
 rtl/rr_prio_encoder_if.sv | 33 +++
 rtl/rr_prio_encoder_prio_pick.sv | 39 +++
 rtl/rr_prio_encoder.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/rr_prio_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_prio_encoder_pkg
// Brief    : Shared types and constants for the rr_prio_encoder arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_prio_encoder_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic MODE_FIXED      = 1'b0;
    localparam logic MODE_RR         = 1'b1;
    localparam int   TIMEOUT_DEFAULT = 16;

endpackage : rr_prio_encoder_pkg
`default_nettype wire

// File: rtl/rr_prio_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_prio_encoder_if
// Brief    : Request/grant bundle; timeout_p exists only with
//            RR_PRIO_ENCODER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_prio_encoder_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic         en_b;
    logic         mode;
    logic [N-1:0] req_b;
    logic         ack;
    logic         grant_vld;
    logic [W-1:0] grant_idx;
    logic [N-1:0] grant_b;
`ifdef RR_PRIO_ENCODER_TIMEOUT_EN
    logic         timeout_p;

    modport master (output en_b, mode, req_b, ack,
                    input  grant_vld, grant_idx, grant_b, timeout_p);
    modport slave  (input  en_b, mode, req_b, ack,
                    output grant_vld, grant_idx, grant_b, timeout_p);
`else
    modport master (output en_b, mode, req_b, ack,
                    input  grant_vld, grant_idx, grant_b);
    modport slave  (input  en_b, mode, req_b, ack,
                    output grant_vld, grant_idx, grant_b);
`endif
endinterface : rr_prio_encoder_if
`default_nettype wire

// File: rtl/rr_prio_encoder_prio_pick.sv
`default_nettype none
// ============================================================================
// Module   : prio_pick
// Brief    : Combinational first-one finder searching upward from a start
//            index with wrap at N-1.
// Revision : 1.0 - initial release
// ============================================================================
module prio_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    // N need not be a power of two, so the wrap is done explicitly
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int off);
        int p;
        p = int'(base) + off;
        if (p >= N) p = p - N;
        return W'(p);
    endfunction

    // Scanning from the far end lets the nearest hit overwrite earlier ones
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[wrap_add(i_start, k)]) begin
                o_found = 1'b1;
                o_idx   = wrap_add(i_start, k);
            end
        end
    end

endmodule : prio_pick
`default_nettype wire

// File: rtl/rr_prio_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rr_prio_encoder
// Brief    : N-way fixed/round-robin arbiter with registered one-hot grant and
//            valid/ack hold. Optional grant timeout: RR_PRIO_ENCODER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_prio_encoder
    import rr_prio_encoder_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
`ifdef RR_PRIO_ENCODER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
    input  logic               clk,
    input  logic               rst,
    rr_prio_encoder_if.slave   bus
);

    function automatic logic [W-1:0] next_idx(input logic [W-1:0] i);
        return (i == W'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    state_t       r_state, w_state_nxt;
    logic         r_vld, w_vld_nxt;
    logic [W-1:0] r_idx, w_idx_nxt;
    logic [N-1:0] r_grant_b, w_grant_b_nxt;
    logic [W-1:0] r_ptr, w_ptr_nxt;
    logic [W-1:0] w_ptr_eff, w_start, w_win_idx;
    logic         w_found, w_accept;

    // An accepted grant re-arbitrates in the same cycle from the advanced pointer
    assign w_accept  = (r_state == GRANT) && bus.ack && !bus.en_b;
    assign w_ptr_eff = (w_accept && bus.mode == MODE_RR) ? next_idx(r_idx) : r_ptr;
    assign w_start   = (bus.mode == MODE_RR) ? w_ptr_eff : '0;

    prio_pick #(.N(N), .W(W)) u_pick (
        .i_req   (~bus.req_b),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_win_idx)
    );

`ifdef RR_PRIO_ENCODER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_tcnt, w_tcnt_nxt;
    logic          r_timeout_p, w_timeout_nxt;
    logic          w_expire;

    assign w_expire   = (r_state == GRANT) && !bus.ack && !bus.en_b &&
                        (r_tcnt == CW'(TIMEOUT - 1));
    assign w_tcnt_nxt = ((r_state == GRANT) && !bus.ack && !bus.en_b && !w_expire)
                        ? r_tcnt + 1'b1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt      <= '0;
            r_timeout_p <= 1'b0;
        end else begin
            r_tcnt      <= w_tcnt_nxt;
            r_timeout_p <= w_timeout_nxt;
        end
    end

    assign bus.timeout_p = r_timeout_p;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_vld_nxt   = r_vld;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
`ifdef RR_PRIO_ENCODER_TIMEOUT_EN
        w_timeout_nxt = 1'b0;
`endif
        if (bus.en_b) begin
            w_state_nxt = IDLE;
            w_vld_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        w_state_nxt = GRANT;
                        w_vld_nxt   = 1'b1;
                        w_idx_nxt   = w_win_idx;
                    end
                end
                GRANT: begin
                    if (bus.ack) begin
                        w_ptr_nxt = w_ptr_eff;
                        if (w_found) begin
                            w_idx_nxt = w_win_idx;
                        end else begin
                            w_state_nxt = IDLE;
                            w_vld_nxt   = 1'b0;
                        end
                    end
`ifdef RR_PRIO_ENCODER_TIMEOUT_EN
                    else if (w_expire) begin
                        w_state_nxt   = IDLE;
                        w_vld_nxt     = 1'b0;
                        w_timeout_nxt = 1'b1;
                        if (bus.mode == MODE_RR) w_ptr_nxt = next_idx(r_idx);
                    end
`endif
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_vld_nxt   = 1'b0;
                end
            endcase
        end
        w_grant_b_nxt = w_vld_nxt ? ~({{(N-1){1'b0}}, 1'b1} << w_idx_nxt) : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_vld     <= 1'b0;
            r_idx     <= '0;
            r_grant_b <= '1;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_vld     <= w_vld_nxt;
            r_idx     <= w_idx_nxt;
            r_grant_b <= w_grant_b_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    assign bus.grant_vld = r_vld;
    assign bus.grant_idx = r_idx;
    assign bus.grant_b   = r_grant_b;

endmodule : rr_prio_encoder
`default_nettype wire
